shftreg_rx: RTL
===============

Name: shftreg_rx

Overview:
- Serial-to-parallel receiver: the receiving end of a link driven by our right-shift transmitter register, which shifts out D[0] first, so bits arrive LSB first.
- Frames serial bits from a strobe-qualified line and assembles WIDTH-bit words.
- Presents each word on a parallel output with a Valid/Ack handshake.
- Flags framing and overrun errors.

Parameters:
- WIDTH, 4, number of data bits per frame (2..16).

Ports:
- CLK  input  1  clock; all state changes on the negative edge.
- Clear  input  1  reset, asynchronous, active-high.
- SIn  input  1  serial data line; idle level 1.
- SEn  input  1  bit strobe; SIn is sampled only on a CLK negedge where SEn=1.
- Q  output  WIDTH  last good received word.
- Valid  output  1  Q holds an unacknowledged word.
- Ack  input  1  consumer accepts Q; sampled on a negedge where Valid=1.
- FrameErr  output  1  sticky: stop bit was 0.
- Overrun  output  1  sticky: new word committed while the previous one was unacknowledged.

Behaviour:
- Reset:
  - Clear=1 asynchronously forces state IDLE, bit counter 0, shift register 0, Q=0, Valid=0, FrameErr=0, Overrun=0.
  - Clear dominates CLK. A Clear mid-frame discards the partial word.
- Frame format: start bit (0), WIDTH data bits LSB first, stop bit (1). One bit per SEn strobe; no oversampling.
- SEn=0 at a negedge: state, counter and shift register hold. Handshake logic still runs.
- FSM (2-bit state; cnt is a $clog2(WIDTH)-bit counter):
  - IDLE: when SEn & SIn=0, go to DATA with cnt=0. When SEn & SIn=1, stay in IDLE.
  - DATA: when SEn, shift right into the MSB: sh = {SIn, sh[WIDTH-1:1]} and cnt++. When cnt==WIDTH-1 at that edge, go to STOP (or to PAR with the optional feature).
  - STOP: when SEn & SIn=1, commit the word (see below) and go to IDLE. When SEn & SIn=0, set FrameErr=1, leave Q and Valid unchanged, and go to IDLE. No resync: the next start bit is searched from the next strobe.
- Commit: Q<=sh and Valid<=1 on the same negedge as the stop bit. Latency from stop-bit edge to Valid is 0 cycles (registered on that edge).
- Handshake:
  - Valid=1 and Ack=1 at a negedge with no commit: Valid<=0 and Q holds.
  - Commit and Ack on the same edge: Q updates, Valid stays 1, no overrun.
  - Commit while Valid=1 and Ack=0: Q is overwritten with the new word, Valid stays 1, Overrun<=1.
  - Ack while Valid=0 is ignored.
- Error flags: FrameErr and Overrun are cleared only by Clear.
- Width rule: cnt compares against WIDTH-1 exactly. The shift register and Q are exactly WIDTH bits; no sign extension.

Optional Feature:
- Macro: SHFTREG_RX_PARITY_EN.
- Defined:
  - Adds state PAR between DATA and STOP and output ParErr (1 bit, sticky, reset 0).
  - In PAR, on SEn, the sampled bit is compared with even parity, i.e. the XOR of the data bits. A mismatch sets ParErr=1.
  - Then go to STOP.
  - A word with a parity mismatch and a good stop bit is still committed.
  - Frame length is WIDTH+3 strobes.
- Not defined:
  - No PAR state and no ParErr port.
  - Frame length is WIDTH+2 strobes.

Test Plan:
1. Clear=1 pulse mid-frame (after start bit + 2 data bits), then a clean frame of 4'b0110 -> after the Clear, all outputs 0 and the FSM is in IDLE; only 4'b0110 is received and no error flags are set.
2. WIDTH=4, SEn every cycle, SIn = 0,0,1,0,1,1 (start, data 4'hA LSB first, stop) -> at the stop negedge Q=4'b1010 and Valid=1. Ack=1 for one edge -> Valid=0, Q stays 4'b1010.
3. Same frame with SEn toggling 1,0 (strobe every other cycle) -> identical result. The state holds on SEn=0 edges.
4. Frame 4'h5 with stop bit 0 -> FrameErr=1, Valid stays 0, Q unchanged (0). A following good frame 4'h3 -> Q=4'b0011, Valid=1, FrameErr still 1.
5. Frames 4'h1 then 4'h2 with no Ack -> Q=4'b0010, Valid=1, Overrun=1. Repeat with Ack asserted on the second commit edge -> Overrun stays 0, Valid=1.
6. With SHFTREG_RX_PARITY_EN: data 4'b0111 with parity bit 0 (expected 1), stop 1 -> Q=4'b0111, Valid=1, ParErr=1. Data 4'b0011 with parity 0 -> ParErr unchanged.

Source files
------------

// File: rtl/shftreg_rx.sv
// Serial-to-parallel receiver: start bit, WIDTH data bits LSB first, stop bit; Valid/Ack output.
// Define SHFTREG_RX_PARITY_EN to add an even-parity bit after the data bits and a sticky ParErr flag.
module shftreg_rx #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             Clear,
   input  logic             SIn,
   input  logic             SEn,
   input  logic             Ack,
   output logic [WIDTH-1:0] Q,
   output logic             Valid,
   output logic             FrameErr,
`ifdef SHFTREG_RX_PARITY_EN
   output logic             ParErr,
`endif
   output logic             Overrun
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
`ifdef SHFTREG_RX_PARITY_EN
      PAR  = 2'd3,
`endif
      STOP = 2'd2
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sh_q;
   logic [WIDTH-1:0] sh_d;
   logic [WIDTH-1:0] q_q;
   logic             valid_q;
   logic             frame_err_q;
   logic             overrun_q;
   logic             commit;
`ifdef SHFTREG_RX_PARITY_EN
   logic             par_err_q;
`endif

   always_comb begin
      sh_d   = {SIn, sh_q[WIDTH-1:1]};
      commit = SEn && SIn && (state_q == STOP);
   end

   always_ff @(negedge CLK or posedge Clear) begin
      if (Clear) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         q_q         <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef SHFTREG_RX_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         if (SEn) begin
            case (state_q)
               IDLE: begin
                  if (!SIn) begin
                     state_q <= DATA;
                     cnt_q   <= '0;
                  end
               end
               DATA: begin
                  sh_q  <= sh_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST) begin
`ifdef SHFTREG_RX_PARITY_EN
                     state_q <= PAR;
`else
                     state_q <= STOP;
`endif
                  end
               end
`ifdef SHFTREG_RX_PARITY_EN
               PAR: begin
                  if (SIn != ^sh_q) par_err_q <= 1'b1;
                  state_q <= STOP;
               end
`endif
               STOP: begin
                  // Bad stop bit drops the word; hunting restarts on the next strobe.
                  if (!SIn) frame_err_q <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end

         // A simultaneous Ack consumes the old word, so only an unacked one overruns.
         if (commit) begin
            q_q     <= sh_q;
            valid_q <= 1'b1;
            if (valid_q && !Ack) overrun_q <= 1'b1;
         end else if (valid_q && Ack) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign Q        = q_q;
   assign Valid    = valid_q;
   assign FrameErr = frame_err_q;
   assign Overrun  = overrun_q;
`ifdef SHFTREG_RX_PARITY_EN
   assign ParErr   = par_err_q;
`endif

endmodule
